mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous RAM between the instruction fetch (IF) port and the MEM
//   stage load/store port. Only one access is in flight at a time. When both ports request,
//   MEM wins unless MEM also got the previous grant, so neither port starves. A store wins over
//   a load raised in the same cycle.
//
//   Read timing, counted from the edge E0 that grants the request:
//     E0            grant, ram_addr latched, ram_re = 1 for one cycle
//     E1            RAM samples ram_re, FSM enters WAIT
//     E(RD_LATENCY+2)  ram_rdata captured into if_data / mem_rdata, valid pulses
//   Store timing: E0 grant with ram_we = 1 for one cycle, mem_valid pulses at E2.
//
// Parameters
//   RD_LATENCY  RAM read latency in clock edges, legal range 1..3
//
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   if_req, if_addr          fetch request (level, held until if_valid) and address
//   mem_rd_req, mem_wr_req   MEM-stage load / store requests (level, held until mem_valid)
//   mem_addr, mem_wdata      MEM-stage address and store data
//   ram_rdata                RAM read data
//   ram_addr, ram_wdata      registered RAM address / write data, stable for a whole access
//   ram_re, ram_we           registered RAM strobes, never both high
//   if_valid, mem_valid      one-cycle completion pulses
//   if_data, mem_rdata       registered read data, held until that port's next completion
//   stall_if, stall_mem      combinational pipeline stall flags

module mem_port_arbiter #(
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       if_req,
   input  logic [7:0] if_addr,
   input  logic       mem_rd_req,
   input  logic       mem_wr_req,
   input  logic [7:0] mem_addr,
   input  logic [7:0] mem_wdata,
   input  logic [7:0] ram_rdata,
   output logic [7:0] ram_addr,
   output logic [7:0] ram_wdata,
   output logic       ram_re,
   output logic       ram_we,
   output logic       if_valid,
   output logic       mem_valid,
   output logic [7:0] if_data,
   output logic [7:0] mem_rdata,
   output logic       stall_if,
   output logic       stall_mem
);

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StWait,
      StWrite
   } state_e;

   // Which requester owns the access in flight.
   typedef enum logic [1:0] {
      GntIf,
      GntLoad,
      GntStore
   } gnt_e;

   // WAIT covers the RAM latency plus the edge that captures ram_rdata, so the counter
   // terminates at RD_LATENCY (entered with 0 one edge after the strobe).
   localparam logic [1:0] WaitLast = 2'(RD_LATENCY);

   state_e     state_q, state_d;
   gnt_e       gnt_q, gnt_d;
   logic [1:0] cnt_q, cnt_d;
   logic       last_mem_q, last_mem_d;
   logic [7:0] ram_addr_q, ram_addr_d;
   logic [7:0] ram_wdata_q, ram_wdata_d;
   logic       ram_re_q, ram_re_d;
   logic       ram_we_q, ram_we_d;
   logic       if_valid_q, if_valid_d;
   logic       mem_valid_q, mem_valid_d;
   logic [7:0] if_data_q, if_data_d;
   logic [7:0] mem_rdata_q, mem_rdata_d;

   // A port whose valid is high this cycle is skipped so its held request is not served twice.
   logic if_pend;
   logic mem_pend;
   logic take_mem;

   assign if_pend  = if_req & ~if_valid_q;
   assign mem_pend = (mem_rd_req | mem_wr_req) & ~mem_valid_q;
   // MEM has priority unless it was served last and IF is waiting too.
   assign take_mem = mem_pend & ~(if_pend & last_mem_q);

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      last_mem_d  = last_mem_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_re_d    = 1'b0;
      ram_we_d    = 1'b0;
      if_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (if_pend || mem_pend) begin
               cnt_d = 2'd0;
               if (take_mem) begin
                  last_mem_d = 1'b1;
                  ram_addr_d = mem_addr;
                  if (mem_wr_req) begin
                     // Store wins over a simultaneous load.
                     gnt_d       = GntStore;
                     ram_wdata_d = mem_wdata;
                     ram_we_d    = 1'b1;
                     state_d     = StWrite;
                  end else begin
                     gnt_d    = GntLoad;
                     ram_re_d = 1'b1;
                     state_d  = StRead;
                  end
               end else begin
                  last_mem_d = 1'b0;
                  ram_addr_d = if_addr;
                  gnt_d      = GntIf;
                  ram_re_d   = 1'b1;
                  state_d    = StRead;
               end
            end
         end

         StRead: begin
            cnt_d   = 2'd0;
            state_d = StWait;
         end

         StWait: begin
            if (cnt_q == WaitLast) begin
               cnt_d   = 2'd0;
               state_d = StIdle;
               if (gnt_q == GntIf) begin
                  if_data_d  = ram_rdata;
                  if_valid_d = 1'b1;
               end else begin
                  mem_rdata_d = ram_rdata;
                  mem_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end

         StWrite: begin
            // First cycle carries the strobe; the second completes the store.
            if (!ram_we_q) begin
               mem_valid_d = 1'b1;
               state_d     = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         gnt_q       <= GntIf;
         cnt_q       <= 2'd0;
         last_mem_q  <= 1'b0;
         ram_addr_q  <= 8'h00;
         ram_wdata_q <= 8'h00;
         ram_re_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         if_data_q   <= 8'h00;
         mem_rdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         last_mem_q  <= last_mem_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_re_q    <= ram_re_d;
         ram_we_q    <= ram_we_d;
         if_valid_q  <= if_valid_d;
         mem_valid_q <= mem_valid_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_re    = ram_re_q;
   assign ram_we    = ram_we_q;
   assign if_valid  = if_valid_q;
   assign mem_valid = mem_valid_q;
   assign if_data   = if_data_q;
   assign mem_rdata = mem_rdata_q;
   assign stall_if  = if_req & ~if_valid_q;
   assign stall_mem = (mem_rd_req | mem_wr_req) & ~mem_valid_q;

endmodule
